sample_window_buffer: RTL



---
 rtl/cussen_pkg.sv | 32 +++
 rtl/frame_hold_reg.sv | 41 ++++
 rtl/sample_window_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cussen_pkg.sv
// Shared types for the sample window front-end: widths, FSM encoding, frame layout.
// Window slot 0 is the oldest sample (win1); slots at or beyond a frame's length read as zero.
package cussen_pkg;
    localparam int WIDTH   = 8;
    localparam int WIN_LEN = 9;
    localparam int LEN_W   = 4;
    localparam int ID_W    = 8;

    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_FULL       = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } state_t;

    typedef logic [WIN_LEN-1:0][WIDTH-1:0] window_t;

    typedef struct packed {
        window_t           win;
        logic [LEN_W-1:0]  len;
        logic              partial;
        logic [ID_W-1:0]   id;
    } frame_t;

    function automatic window_t mask_window(input window_t w, input logic [LEN_W-1:0] len);
        window_t m;
        m = w;
        for (int i = 0; i < WIN_LEN; i++) begin
            if (LEN_W'(i) >= len) m[i] = '0;
        end
        return m;
    endfunction
endpackage

// File: rtl/frame_hold_reg.sv
// One-entry output holding register with valid/ready; load appears on out_* the next cycle.
// Contents stay frozen while out_vld && !out_rdy; callers must load only when out_free is high.
module frame_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_vld,
    input  logic [W-1:0] load_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_free
);
    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    assign out_free = !vld_q || out_rdy;
    assign out_vld  = vld_q;
    assign out_dat  = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (vld_q && out_rdy) vld_d = 1'b0;
        if (load_vld) begin
            vld_d = 1'b1;
            dat_d = load_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

// File: rtl/sample_window_buffer.sv
// Packs a serial sample stream into 9-slot windows; a completed window is on win1..9 the cycle after its last accept.
// One finished window can wait in the fill register behind a held output frame; sample_ready drops only then.
module sample_window_buffer
    import cussen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] win1,
    output logic [WIDTH-1:0] win2,
    output logic [WIDTH-1:0] win3,
    output logic [WIDTH-1:0] win4,
    output logic [WIDTH-1:0] win5,
    output logic [WIDTH-1:0] win6,
    output logic [WIDTH-1:0] win7,
    output logic [WIDTH-1:0] win8,
    output logic [WIDTH-1:0] win9,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [3:0]       frame_len,
    output logic             frame_partial,
    output logic [7:0]       frame_id
);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIN_LEN);

    state_t            state_q, state_d;
    window_t           fill_q, fill_d, fill_next;
    logic [LEN_W-1:0]  cnt_q, cnt_d, eff_cnt, len_sel;
    logic [ID_W-1:0]   id_q, id_d;
    logic              accept, out_free, load_vld;
    frame_t            load_dat, hold_dat;

    assign sample_ready = rst_n && (state_q == ST_FILL);
    assign accept       = sample_valid && sample_ready;

    always_comb begin
        fill_next = fill_q;
        for (int i = 0; i < WIN_LEN; i++) begin
            if (accept && cnt_q == LEN_W'(i)) fill_next[i] = sample_in;
        end
        eff_cnt = cnt_q + LEN_W'(accept);
        // Waiting states hold a finished window of length cnt_q; FILL emits including this cycle's sample.
        len_sel = (state_q == ST_FILL) ? eff_cnt : cnt_q;

        load_dat.win     = mask_window(fill_next, len_sel);
        load_dat.len     = len_sel;
        load_dat.partial = (len_sel != FULL_LEN);
        load_dat.id      = id_q;

        state_d  = state_q;
        fill_d   = fill_next;
        cnt_d    = cnt_q;
        id_d     = id_q;
        load_vld = 1'b0;

        case (state_q)
            ST_FILL: begin
                cnt_d = eff_cnt;
                if (eff_cnt == FULL_LEN || (flush && eff_cnt != '0)) begin
                    if (out_free) begin
                        load_vld = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = (eff_cnt == FULL_LEN) ? ST_FULL : ST_FLUSH_PEND;
                    end
                end
            end
            ST_FULL, ST_FLUSH_PEND: begin
                if (out_free) begin
                    load_vld = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (load_vld) id_d = id_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    frame_hold_reg #(.W($bits(frame_t))) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (load_vld),
        .load_dat (load_dat),
        .out_vld  (frame_valid),
        .out_rdy  (frame_ready),
        .out_dat  (hold_dat),
        .out_free (out_free)
    );

    assign win1          = hold_dat.win[0];
    assign win2          = hold_dat.win[1];
    assign win3          = hold_dat.win[2];
    assign win4          = hold_dat.win[3];
    assign win5          = hold_dat.win[4];
    assign win6          = hold_dat.win[5];
    assign win7          = hold_dat.win[6];
    assign win8          = hold_dat.win[7];
    assign win9          = hold_dat.win[8];
    assign frame_len     = hold_dat.len;
    assign frame_partial = hold_dat.partial;
    assign frame_id      = hold_dat.id;
endmodule
